// File: rtl/stb_pkg.sv
// Shared types and default widths for the store-buffer drain controller.
package stb_pkg;
  localparam int STB_ADDR_WIDTH     = 32;
  localparam int STB_DATA_WIDTH     = 32;
  localparam int STB_BYTE_SEL_WIDTH = 4;

  typedef struct packed {
    logic [STB_ADDR_WIDTH-1:0]     addr;
    logic [STB_DATA_WIDTH-1:0]     wdata;
    logic [STB_BYTE_SEL_WIDTH-1:0] sel_byte;
  } stb_entry_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_POP    = 3'd2,
    ST_SETTLE = 3'd3,
    ST_ERROR  = 3'd4
  } stb_drain_state_e;
endpackage

// File: rtl/stb_drain_ctrl_if.sv
// Store-buffer head, dcache write port and LSU flush handshake bundled together.
interface stb_drain_ctrl_if
  import stb_pkg::*;
#(
  parameter int ADDR_WIDTH     = STB_ADDR_WIDTH,
  parameter int DATA_WIDTH     = STB_DATA_WIDTH,
  parameter int BYTE_SEL_WIDTH = STB_BYTE_SEL_WIDTH
);
  logic                      stb_empty;
  logic [ADDR_WIDTH-1:0]     stb_head_addr;
  logic [DATA_WIDTH-1:0]     stb_head_wdata;
  logic [BYTE_SEL_WIDTH-1:0] stb_head_sel_byte;
  logic                      rd_sel;
  logic                      r_en;
  logic [ADDR_WIDTH-1:0]     stb2dcache_addr;
  logic [DATA_WIDTH-1:0]     stb2dcache_wdata;
  logic [BYTE_SEL_WIDTH-1:0] stb2dcache_sel_byte;
  logic                      stb2dcache_req;
  logic                      stb2dcache_w_en;
  logic                      dcache2stb_ack;
  logic                      lsu2stb_flush_req;
  logic                      stb2lsu_flush_done;
  logic                      stb_timeout_err;

  modport master (
    input  stb_empty, stb_head_addr, stb_head_wdata, stb_head_sel_byte,
           dcache2stb_ack, lsu2stb_flush_req,
    output rd_sel, r_en, stb2dcache_addr, stb2dcache_wdata, stb2dcache_sel_byte,
           stb2dcache_req, stb2dcache_w_en, stb2lsu_flush_done, stb_timeout_err
  );

  modport slave (
    output stb_empty, stb_head_addr, stb_head_wdata, stb_head_sel_byte,
           dcache2stb_ack, lsu2stb_flush_req,
    input  rd_sel, r_en, stb2dcache_addr, stb2dcache_wdata, stb2dcache_sel_byte,
           stb2dcache_req, stb2dcache_w_en, stb2lsu_flush_done, stb_timeout_err
  );
endinterface

// File: rtl/stb_ack_timer.sv
// Counts REQ cycles without an acknowledge; expired marks the last allowed cycle.
module stb_ack_timer #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic tick,
  output logic expired
);
  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) cnt <= '0;
    else if (tick)    cnt <= cnt + 1'b1;
  end

  assign expired = (cnt == CW'(ACK_TIMEOUT - 1));
endmodule

// File: rtl/stb_drain_ctrl.sv
// Drains the store buffer head to the dcache one entry at a time, with ack
// timeout and fence/flush completion signalling.
module stb_drain_ctrl
  import stb_pkg::*;
#(
  parameter int ADDR_WIDTH     = STB_ADDR_WIDTH,
  parameter int DATA_WIDTH     = STB_DATA_WIDTH,
  parameter int BYTE_SEL_WIDTH = STB_BYTE_SEL_WIDTH,
  parameter int ACK_TIMEOUT    = 16
) (
  input logic              clk,
  input logic              rst,
  stb_drain_ctrl_if.master bus
);
  localparam logic [2:0] IDLE   = 3'(ST_IDLE);
  localparam logic [2:0] REQ    = 3'(ST_REQ);
  localparam logic [2:0] POP    = 3'(ST_POP);
  localparam logic [2:0] SETTLE = 3'(ST_SETTLE);
  localparam logic [2:0] ERROR  = 3'(ST_ERROR);

  logic [2:0]                state, state_nxt;
  logic                      capture, ack_acc, timer_tick, timer_exp;
  logic                      flush_pending, flush_fire, done_q;
  logic [ADDR_WIDTH-1:0]     addr_q;
  logic [DATA_WIDTH-1:0]     wdata_q;
  logic [BYTE_SEL_WIDTH-1:0] sel_q;

  assign capture    = (state == IDLE) && !bus.stb_empty;
  assign ack_acc    = (state == REQ) && bus.dcache2stb_ack;
  assign timer_tick = (state == REQ) && !bus.dcache2stb_ack;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!bus.stb_empty) state_nxt = REQ;
      REQ:     if (ack_acc)        state_nxt = POP;
               else if (timer_exp) state_nxt = ERROR;
      POP:     state_nxt = SETTLE;
      // SETTLE lets the buffer's registered empty flag catch up with the pop
      SETTLE:  state_nxt = IDLE;
      ERROR:   state_nxt = ERROR;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
    end else if (capture) begin
      addr_q  <= bus.stb_head_addr;
      wdata_q <= bus.stb_head_wdata;
      sel_q   <= bus.stb_head_sel_byte;
    end
  end

  stb_ack_timer #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_ack_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (capture),
    .tick    (timer_tick),
    .expired (timer_exp)
  );

  // A request seen this cycle counts immediately so an already-idle flush completes next cycle
  assign flush_fire = (state == IDLE) && bus.stb_empty &&
                      (flush_pending || bus.lsu2stb_flush_req);

  always_ff @(posedge clk) begin
    if (rst) begin
      flush_pending <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      done_q <= flush_fire;
      if (flush_fire)                 flush_pending <= 1'b0;
      else if (bus.lsu2stb_flush_req) flush_pending <= 1'b1;
    end
  end

  assign bus.rd_sel              = capture && !rst;
  assign bus.r_en                = (state == POP);
  assign bus.stb2dcache_req      = (state == REQ);
  assign bus.stb2dcache_w_en     = (state == REQ);
  assign bus.stb2dcache_addr     = addr_q;
  assign bus.stb2dcache_wdata    = wdata_q;
  assign bus.stb2dcache_sel_byte = sel_q;
  assign bus.stb2lsu_flush_done  = done_q;
  assign bus.stb_timeout_err     = (state == ERROR);
endmodule

// File: tb/tb_stb_drain_ctrl.sv
// Bench for stb_drain_ctrl: vector table, directed corner cases and a randomized
// run scored against a transaction-level model of the drain/flush rules.
module tb_stb_drain_ctrl;
  import stb_pkg::*;

  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stb_drain_ctrl_if bus ();

  stb_drain_ctrl #(
    .ADDR_WIDTH     (STB_ADDR_WIDTH),
    .DATA_WIDTH     (STB_DATA_WIDTH),
    .BYTE_SEL_WIDTH (STB_BYTE_SEL_WIDTH),
    .ACK_TIMEOUT    (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  stb_entry_t sb_q[$];

  typedef struct {
    bit push, ack, flush;
    bit e_rdsel, e_req, e_ren, e_done, e_err;
  } vec_t;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chke(input string name, input stb_entry_t act, input stb_entry_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic stb_entry_t dut_entry();
    stb_entry_t e;
    e.addr     = bus.stb2dcache_addr;
    e.wdata    = bus.stb2dcache_wdata;
    e.sel_byte = bus.stb2dcache_sel_byte;
    return e;
  endfunction

  task automatic drive_sb();
    if (sb_q.size() == 0) begin
      bus.stb_empty         = 1'b1;
      bus.stb_head_addr     = '0;
      bus.stb_head_wdata    = '0;
      bus.stb_head_sel_byte = '0;
    end else begin
      bus.stb_empty         = 1'b0;
      bus.stb_head_addr     = sb_q[0].addr;
      bus.stb_head_wdata    = sb_q[0].wdata;
      bus.stb_head_sel_byte = sb_q[0].sel_byte;
    end
  endtask

  // Store buffer pops its head on any edge where r_en was high
  task automatic tick();
    logic ren;
    ren = bus.r_en;
    @(posedge clk);
    if (ren && sb_q.size() > 0) void'(sb_q.pop_front());
    cyc++;
    #1;
    drive_sb();
    #1;
  endtask

  task automatic push(input stb_entry_t e);
    sb_q.push_back(e);
    drive_sb();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.dcache2stb_ack    = 1'b0;
    bus.lsu2stb_flush_req = 1'b0;
    sb_q.delete();
    drive_sb();
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk1({tag, "_rd_sel"}, bus.rd_sel, 1'b0);
    chk1({tag, "_r_en"}, bus.r_en, 1'b0);
    chk1({tag, "_req"}, bus.stb2dcache_req, 1'b0);
    chk1({tag, "_w_en"}, bus.stb2dcache_w_en, 1'b0);
    chk1({tag, "_done"}, bus.stb2lsu_flush_done, 1'b0);
    chk1({tag, "_err"}, bus.stb_timeout_err, 1'b0);
    chke({tag, "_regs"}, dut_entry(), '0);
  endtask

  initial begin
    vec_t       vecs[16];
    stb_entry_t ent0;
    stb_entry_t ents[4];
    int         rises[$];
    int         rens[$];
    stb_entry_t caps[$];
    int         n, req_cnt, ren_cnt, err_first, last_req, done_cnt, done_cyc, last_ren, age, dly;
    bit         prev_req, prev_acc, prev_fire, pend, quiet, fire, req, ren;
    stb_entry_t exp_q[$];
    stb_entry_t cap, e;

    ent0 = '{32'h0000_1000, 32'hDEAD_BEEF, 4'b1111};
    //           push ack flush | rdsel req ren done err
    vecs[0]  = '{1, 0, 0, 1, 0, 0, 0, 0};
    vecs[1]  = '{0, 0, 0, 0, 1, 0, 0, 0};
    vecs[2]  = '{0, 0, 0, 0, 1, 0, 0, 0};
    vecs[3]  = '{0, 0, 0, 0, 1, 0, 0, 0};
    vecs[4]  = '{0, 1, 0, 0, 1, 0, 0, 0};
    vecs[5]  = '{0, 0, 0, 0, 0, 1, 0, 0};
    vecs[6]  = '{0, 1, 0, 0, 0, 0, 0, 0};
    vecs[7]  = '{0, 0, 1, 0, 0, 0, 0, 0};
    vecs[8]  = '{0, 0, 0, 0, 0, 0, 1, 0};
    vecs[9]  = '{0, 1, 0, 0, 0, 0, 0, 0};
    vecs[10] = '{0, 0, 0, 0, 0, 0, 0, 0};
    vecs[11] = '{1, 0, 0, 1, 0, 0, 0, 0};
    vecs[12] = '{0, 1, 0, 0, 1, 0, 0, 0};
    vecs[13] = '{0, 0, 0, 0, 0, 1, 0, 0};
    vecs[14] = '{0, 0, 0, 0, 0, 0, 0, 0};
    vecs[15] = '{0, 0, 0, 0, 0, 0, 0, 0};

    rst = 1'b1;
    bus.dcache2stb_ack    = 1'b0;
    bus.lsu2stb_flush_req = 1'b0;
    drive_sb();

    // Reset state
    do_reset();
    chk_all_zero("reset");

    // Single store, flush when idle, stray acks, ack on the first req cycle
    for (int i = 0; i < 16; i++) begin
      if (vecs[i].push) push(ent0);
      bus.dcache2stb_ack    = vecs[i].ack;
      bus.lsu2stb_flush_req = vecs[i].flush;
      #1;
      chk1($sformatf("vec%0d_rd_sel", i), bus.rd_sel, vecs[i].e_rdsel);
      chk1($sformatf("vec%0d_req", i), bus.stb2dcache_req, vecs[i].e_req);
      chk1($sformatf("vec%0d_w_en", i), bus.stb2dcache_w_en, vecs[i].e_req);
      chk1($sformatf("vec%0d_r_en", i), bus.r_en, vecs[i].e_ren);
      chk1($sformatf("vec%0d_done", i), bus.stb2lsu_flush_done, vecs[i].e_done);
      chk1($sformatf("vec%0d_err", i), bus.stb_timeout_err, vecs[i].e_err);
      if (vecs[i].e_req) chke($sformatf("vec%0d_entry", i), dut_entry(), ent0);
      tick();
    end
    bus.dcache2stb_ack    = 1'b0;
    bus.lsu2stb_flush_req = 1'b0;

    // Back-to-back drain of 4 entries, ack on the first req cycle
    do_reset();
    for (int i = 0; i < 4; i++) begin
      ents[i] = '{32'h2000 + 32'(i * 4), $urandom, 4'(i + 1)};
      sb_q.push_back(ents[i]);
    end
    drive_sb();
    #1;
    prev_req = 1'b0;
    for (int k = 0; k < 40; k++) begin
      bus.dcache2stb_ack = bus.stb2dcache_req;
      if (bus.stb2dcache_req && !prev_req) begin
        rises.push_back(cyc);
        caps.push_back(dut_entry());
      end
      if (bus.r_en) rens.push_back(cyc);
      prev_req = bus.stb2dcache_req;
      tick();
    end
    bus.dcache2stb_ack = 1'b0;
    chki("b2b_req_count", rises.size(), 4);
    chki("b2b_ren_count", rens.size(), 4);
    if (rises.size() == 4 && rens.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chki($sformatf("b2b_spacing%0d", i), rises[i] - rises[0], 4 * i);
        chki($sformatf("b2b_ren_lat%0d", i), rens[i] - rises[i], 1);
        chke($sformatf("b2b_order%0d", i), caps[i], ents[i]);
      end
    end
    chki("b2b_sb_drained", sb_q.size(), 0);
    chk1("b2b_idle_req", bus.stb2dcache_req, 1'b0);

    // Timeout: no ack ever
    do_reset();
    push(ent0);
    req_cnt = 0; ren_cnt = 0; err_first = -1; last_req = -1;
    for (int k = 0; k < 40; k++) begin
      if (bus.stb2dcache_req) begin req_cnt++; last_req = cyc; end
      if (bus.r_en) ren_cnt++;
      if (bus.stb_timeout_err && err_first < 0) err_first = cyc;
      tick();
    end
    chki("to_req_cycles", req_cnt, TO);
    chki("to_err_latency", err_first - last_req, 1);
    chki("to_no_ren", ren_cnt, 0);
    chk1("to_err_sticky", bus.stb_timeout_err, 1'b1);
    chk1("to_req_low", bus.stb2dcache_req, 1'b0);
    chk1("to_w_en_low", bus.stb2dcache_w_en, 1'b0);
    // Flush never completes in ERROR; acks ignored there
    done_cnt = 0;
    bus.lsu2stb_flush_req = 1'b1;
    bus.dcache2stb_ack    = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (bus.stb2lsu_flush_done || bus.r_en) done_cnt++;
    end
    chki("err_no_flush_done", done_cnt, 0);
    chk1("err_still_set", bus.stb_timeout_err, 1'b1);

    // Timeout boundary: ack on the 16th req cycle wins
    do_reset();
    push(ent0);
    for (int k = 0; k < 4 && !bus.stb2dcache_req; k++) tick();
    for (n = 1; n <= TO; n++) begin
      bus.dcache2stb_ack = (n == TO);
      if (!bus.stb2dcache_req) break;
      tick();
    end
    bus.dcache2stb_ack = 1'b0;
    chki("to_edge_req_cycles", n, TO + 1);
    chk1("to_edge_ren", bus.r_en, 1'b1);
    chk1("to_edge_no_err", bus.stb_timeout_err, 1'b0);
    tick();
    tick();
    chk1("to_edge_no_err_later", bus.stb_timeout_err, 1'b0);

    // Flush with 2 entries queued, ack one cycle after each req
    do_reset();
    push(ent0);
    push('{32'h0000_1004, 32'h1234_5678, 4'b0011});
    bus.lsu2stb_flush_req = 1'b1;
    done_cnt = 0; done_cyc = -1; last_ren = -1; age = 0;
    for (int k = 0; k < 40; k++) begin
      bus.dcache2stb_ack = bus.stb2dcache_req && (age == 1);
      age = bus.stb2dcache_req ? age + 1 : 0;
      if (bus.r_en) last_ren = cyc;
      if (bus.stb2lsu_flush_done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
        bus.lsu2stb_flush_req = 1'b0;
      end
      tick();
    end
    bus.dcache2stb_ack = 1'b0;
    chki("flush2_done_once", done_cnt, 1);
    chki("flush2_done_time", done_cyc - last_ren, 3);

    // Flush with an empty buffer completes one cycle later
    bus.lsu2stb_flush_req = 1'b1;
    tick();
    bus.lsu2stb_flush_req = 1'b0;
    chk1("flush_empty_done", bus.stb2lsu_flush_done, 1'b1);
    tick();
    chk1("flush_empty_single", bus.stb2lsu_flush_done, 1'b0);

    // Reset mid-REQ followed by a late ack
    do_reset();
    push(ent0);
    for (int k = 0; k < 4 && !bus.stb2dcache_req; k++) tick();
    tick();
    chk1("rstreq_in_req", bus.stb2dcache_req, 1'b1);
    rst = 1'b1;
    sb_q.delete();
    drive_sb();
    tick();
    rst = 1'b0;
    bus.dcache2stb_ack = 1'b1;
    #1;
    chk_all_zero("rstreq_after");
    ren_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      bus.dcache2stb_ack = 1'b0;
      if (bus.r_en || bus.stb2dcache_req) ren_cnt++;
    end
    chki("rstreq_no_pop", ren_cnt, 0);

    // Randomized run against the transaction-level model
    do_reset();
    prev_req = 0; prev_acc = 0; prev_fire = 0; pend = 0;
    last_ren = -10; age = 0; dly = 0;
    for (int k = 0; k < 800; k++) begin
      req = bus.stb2dcache_req;
      ren = bus.r_en;
      chk1("rnd_ren", ren, prev_acc);
      chk1("rnd_done", bus.stb2lsu_flush_done, prev_fire);
      chk1("rnd_err", bus.stb_timeout_err, 1'b0);
      chk1("rnd_w_en", bus.stb2dcache_w_en, req);
      if (req && !prev_req) begin
        if (exp_q.size() == 0) chki("rnd_req_without_entry", 1, 0);
        else chke("rnd_order", dut_entry(), exp_q[0]);
        chk1("rnd_req_gap", (cyc - last_ren) >= 3, 1'b1);
        cap = dut_entry();
        age = 0;
        dly = $urandom_range(0, 4);
      end else if (req) begin
        chke("rnd_stable", dut_entry(), cap);
      end
      if (ren) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        last_ren = cyc;
      end
      if (sb_q.size() < 4 && ($urandom % 3) == 0) begin
        e = '{$urandom, $urandom, 4'($urandom)};
        exp_q.push_back(e);
        push(e);
      end
      bus.dcache2stb_ack    = req ? (age == dly) : (($urandom % 4) == 0);
      bus.lsu2stb_flush_req = (($urandom % 12) == 0);
      #1;
      quiet = !req && !ren && (cyc != last_ren + 1);
      chk1("rnd_rd_sel", bus.rd_sel, quiet && !bus.stb_empty);
      fire  = quiet && bus.stb_empty && (pend || bus.lsu2stb_flush_req);
      pend  = fire ? 1'b0 : (bus.lsu2stb_flush_req ? 1'b1 : pend);
      prev_acc  = req && bus.dcache2stb_ack;
      prev_fire = fire;
      prev_req  = req;
      if (req) age++;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/stb_drain_ctrl.md
STB_DRAIN_CTRL -- requirements
Module: stb_drain_ctrl

Interface
REQ-001 Parameters SHALL be as follows:
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width.
- BYTE_SEL_WIDTH, 4, byte-select width.
- ACK_TIMEOUT, 16, maximum number of cycles in REQ without an acknowledge (>=2).
REQ-002 Ports SHALL be as follows:
- clk  in  1  single clock, all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- stb_empty  in  1  store buffer empty flag.
- stb_head_addr  in  ADDR_WIDTH  head-entry address.
- stb_head_wdata  in  DATA_WIDTH  head-entry data.
- stb_head_sel_byte  in  BYTE_SEL_WIDTH  head-entry byte select.
- rd_sel  out  1  head-mux select to the store buffer.
- r_en  out  1  pop-head pulse to the store buffer.
- stb2dcache_addr  out  ADDR_WIDTH  registered store address.
- stb2dcache_wdata  out  DATA_WIDTH  registered store data.
- stb2dcache_sel_byte  out  BYTE_SEL_WIDTH  registered byte select.
- stb2dcache_req  out  1  dcache request.
- stb2dcache_w_en  out  1  dcache write enable.
- dcache2stb_ack  in  1  dcache acknowledge, 1-cycle pulse.
- lsu2stb_flush_req  in  1  fence/flush request, level-sensitive.
- stb2lsu_flush_done  out  1  flush-complete pulse.
- stb_timeout_err  out  1  sticky acknowledge-timeout error.

Function
REQ-003 The FSM SHALL have exactly five states: IDLE, REQ, POP, SETTLE and ERROR.
REQ-004 In IDLE with stb_empty=0, rd_sel SHALL be 1 combinationally, the head entry SHALL be captured into the stb2dcache_* registers on that edge, and the FSM SHALL move to REQ.
REQ-005 In REQ, stb2dcache_req and stb2dcache_w_en SHALL be 1, and addr, wdata and sel_byte SHALL be held stable until an acknowledge is accepted.
REQ-006 An acknowledge in REQ SHALL move the FSM to POP, and req and w_en SHALL be 0 from the next cycle.
REQ-007 POP SHALL assert r_en for exactly one cycle and then move to SETTLE.
REQ-008 SETTLE SHALL last one cycle and then move to IDLE, so that a stale registered stb_empty is never sampled.
REQ-009 The latency from stb_empty falling in cycle N SHALL be: req=1 at N+1; an ack at cycle M gives r_en at M+1; the earliest next req is at M+4.
REQ-010 rd_sel SHALL be 0 outside the IDLE capture cycle, and r_en SHALL be 0 outside POP.
REQ-011 dcache2stb_ack SHALL be ignored in every state except REQ, and an ack arriving in the same cycle req first rises SHALL be accepted.
REQ-012 A timeout counter of width $clog2(ACK_TIMEOUT+1) SHALL clear on REQ entry and increment each REQ cycle without an ack.
REQ-013 When the timeout counter reaches ACK_TIMEOUT-1 with no ack, the FSM SHALL go to ERROR and stb_timeout_err SHALL be set on the next edge.
REQ-014 An ack in the same cycle as the timeout condition SHALL win: the FSM goes to POP and no error is raised.
REQ-015 ERROR SHALL keep req, w_en and r_en at 0, SHALL keep stb_timeout_err at 1, and SHALL exit only by reset.
REQ-016 When lsu2stb_flush_req=1 is seen in any cycle, an internal flush_pending flag SHALL be set.
REQ-017 stb2lsu_flush_done SHALL pulse for one cycle on the edge after the FSM is in IDLE with stb_empty=0 deasserted (stb_empty=1) and flush_pending=1, and flush_pending SHALL clear in that same cycle.
REQ-018 A flush requested while the store buffer is already empty and the FSM is in IDLE SHALL complete with done=1 exactly one cycle later.
REQ-019 A flush SHALL never complete in ERROR.
REQ-020 A flush_req held high after done SHALL re-arm flush_pending, producing one done per drained-and-idle opportunity.
REQ-021 Draining SHALL be strictly in order, with at most one outstanding dcache request.

Reset
REQ-022 With rst=1 at a clock edge, the FSM SHALL enter IDLE, and all outputs, the stb2dcache_* registers, the timeout counter and flush_pending SHALL be 0.
REQ-023 A reset during REQ or POP SHALL drop req and r_en on the next edge with no pop issued, and a late ack arriving after reset SHALL be ignored.

Structure
REQ-024 Package stb_pkg SHALL hold the default ADDR_WIDTH, DATA_WIDTH and BYTE_SEL_WIDTH values, the stb_entry_t struct {addr, wdata, sel_byte} and the stb_drain_state_e enum.
REQ-025 The timeout counter SHALL be the single sub-module stb_ack_timer (ports clk, rst, clear, tick, expired); all other logic SHALL be flat.

Verification
REQ-026 Single store: head {0x0000_1000, 0xDEAD_BEEF, 4'b1111}, ack 3 cycles after req -> one req/w_en burst with stable values, one r_en pulse at ack+1, next IDLE.
REQ-027 Back-to-back drain: 4 entries, ack on the first req cycle each time -> 4 in-order requests spaced 4 cycles apart, 4 r_en pulses, stb_empty observed 1.
REQ-028 Timeout: ACK_TIMEOUT=16, ack never given -> req high for 16 cycles, then err=1 and req=0, no r_en; ack at cycle 16 -> no error.
REQ-029 Flush: flush_req=1 with 2 entries queued -> done pulses once, 1 cycle after the second SETTLE-to-IDLE; flush with an empty buffer -> done at +1 cycle.
REQ-030 Reset mid-REQ: rst=1 for 1 cycle during REQ, followed by an ack -> req=0, r_en never asserted, all outputs 0, the ack ignored.
